spectral_mac_engine: RTL and testbench

SPECTRAL_MAC_ENGINE -- requirements
Module: spectral_mac_engine

---
 rtl/spectral_mac_engine_if.sv | 29 ++
 rtl/spectral_mac_engine.sv | 170 +++++++++++++++++
 tb/tb_spectral_mac_engine.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spectral_mac_engine_if.sv
// Kernel-load, input-row and output-row streams of the spectral MAC engine, plus its status flags.
interface spectral_mac_engine_if #(
  parameter int DATALEN = 16,
  parameter int FFTCHNL = 8
);
  logic                           k_valid;
  logic [2*DATALEN-1:0]           k_data;
  logic                           k_ready;
  logic                           k_loaded;
  logic                           in_valid;
  logic [FFTCHNL*2*DATALEN-1:0]   in_data;
  logic                           in_ready;
  logic                           out_valid;
  logic [FFTCHNL*2*DATALEN-1:0]   out_data;
  logic                           out_last;
  logic                           out_ready;
  logic                           busy;
  logic                           sat_flag;

  modport master (
    output k_valid, k_data, in_valid, in_data, out_ready,
    input  k_ready, k_loaded, in_ready, out_valid, out_data, out_last, busy, sat_flag
  );

  modport slave (
    input  k_valid, k_data, in_valid, in_data, out_ready,
    output k_ready, k_loaded, in_ready, out_valid, out_data, out_last, busy, sat_flag
  );
endinterface

// File: rtl/spectral_mac_engine.sv
// Complex multiply-accumulate of input spectral rows against a resident kernel set,
// summed over CIN input channels and drained as COUT rounded, saturated output tiles.
module spectral_mac_engine #(
  parameter int DATALEN = 16,
  parameter int FFTCHNL = 8,
  parameter int CIN     = 2,
  parameter int COUT    = 2,
  parameter int FRAC    = 15
) (
  input logic                  clk,
  input logic                  rstn,
  spectral_mac_engine_if.slave bus
);

  localparam int W2     = 2 * DATALEN;
  localparam int PW     = 2 * DATALEN + 1;
  localparam int AW     = PW + $clog2(CIN);
  localparam int AW1    = AW + 1;
  localparam int KTOTAL = COUT * CIN * FFTCHNL * FFTCHNL;
  localparam int KIW    = (KTOTAL > 1) ? $clog2(KTOTAL) : 1;
  localparam int RW     = (FFTCHNL > 1) ? $clog2(FFTCHNL) : 1;
  localparam int CIW    = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int COW    = (COUT > 1) ? $clog2(COUT) : 1;

  localparam logic signed [AW1-1:0] RND  = AW1'(1) <<< (FRAC - 1);
  localparam logic signed [AW1-1:0] MAXV = AW1'(2 ** (DATALEN - 1) - 1);
  localparam logic signed [AW1-1:0] MINV = AW1'(-(2 ** (DATALEN - 1)));

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state, state_d;
  logic [W2-1:0]    kmem [KTOTAL];
  logic [KIW-1:0]   kidx;
  logic             k_loaded_r, sat_r;
  logic [RW-1:0]    in_row, out_row;
  logic [CIW-1:0]   in_cin;
  logic [COW-1:0]   out_cout;
  logic             k_fire, in_fire, out_fire, last_in, last_beat, sat_any;
  logic [FFTCHNL-1:0]          clip_re, clip_im;
  logic [FFTCHNL*W2-1:0]       out_word;
  logic signed [AW-1:0]        rd_re [COUT][FFTCHNL];
  logic signed [AW-1:0]        rd_im [COUT][FFTCHNL];

  assign bus.k_ready   = (state == IDLE);
  assign bus.in_ready  = k_loaded_r && !(state == IDLE && bus.k_valid) && (state != DRAIN);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_last  = (state == DRAIN) && last_beat;
  assign bus.busy      = (state != IDLE);
  assign bus.sat_flag  = sat_r;
  assign bus.k_loaded  = k_loaded_r;
  assign bus.out_data  = out_word;

  assign k_fire    = bus.k_valid && bus.k_ready;
  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign last_in   = (in_row == RW'(FFTCHNL - 1)) && (in_cin == CIW'(CIN - 1));
  assign last_beat = (out_row == RW'(FFTCHNL - 1)) && (out_cout == COW'(COUT - 1));
  assign sat_any   = |{clip_re, clip_im};

  // Round half-up, drop FRAC bits, clamp; the MSB of the result flags a clip.
  function automatic logic [DATALEN:0] round_sat(input logic signed [AW-1:0] a);
    logic signed [AW1-1:0] r;
    r = ($signed({a[AW-1], a}) + RND) >>> FRAC;
    if (r > MAXV)      return {1'b1, MAXV[DATALEN-1:0]};
    else if (r < MINV) return {1'b1, MINV[DATALEN-1:0]};
    return {1'b0, r[DATALEN-1:0]};
  endfunction

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_fire) state_d = last_in ? DRAIN : ACCUM;
      ACCUM:   if (in_fire && last_in) state_d = DRAIN;
      DRAIN:   if (out_fire && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      kidx       <= '0;
      k_loaded_r <= 1'b0;
      in_row     <= '0;
      in_cin     <= '0;
      out_row    <= '0;
      out_cout   <= '0;
      sat_r      <= 1'b0;
    end else begin
      state <= state_d;
      if (k_fire) begin
        kidx <= (kidx == KIW'(KTOTAL - 1)) ? '0 : kidx + KIW'(1);
        if (kidx == '0)                k_loaded_r <= 1'b0;
        if (kidx == KIW'(KTOTAL - 1))  k_loaded_r <= 1'b1;
      end
      if (in_fire) begin
        if (in_row == RW'(FFTCHNL - 1)) begin
          in_row <= '0;
          in_cin <= (in_cin == CIW'(CIN - 1)) ? '0 : in_cin + CIW'(1);
        end else begin
          in_row <= in_row + RW'(1);
        end
        if (state == IDLE) sat_r <= 1'b0;
      end
      if (out_fire) begin
        if (out_row == RW'(FFTCHNL - 1)) begin
          out_row  <= '0;
          out_cout <= (out_cout == COW'(COUT - 1)) ? '0 : out_cout + COW'(1);
        end else begin
          out_row <= out_row + RW'(1);
        end
        if (sat_any) sat_r <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (k_fire) kmem[kidx] <= bus.k_data;
  end

  // One complex MAC lane per (cout, point); cin 0 overwrites so no clear cycle is needed.
  for (genvar co = 0; co < COUT; co++) begin : g_co
    for (genvar p = 0; p < FFTCHNL; p++) begin : g_pt
      logic [W2-1:0]              kw;
      logic signed [DATALEN-1:0]  xr, xi, kr, ki;
      logic signed [W2-1:0]       m_ac, m_bd, m_ad, m_bc;
      logic signed [PW-1:0]       pr, pi;
      logic signed [AW-1:0]       acc_re [FFTCHNL];
      logic signed [AW-1:0]       acc_im [FFTCHNL];

      assign kw   = kmem[KIW'(((co * CIN + int'(in_cin)) * FFTCHNL + int'(in_row)) * FFTCHNL + p)];
      assign xr   = bus.in_data[p*W2 +: DATALEN];
      assign xi   = bus.in_data[p*W2+DATALEN +: DATALEN];
      assign kr   = kw[DATALEN-1:0];
      assign ki   = kw[W2-1:DATALEN];
      assign m_ac = xr * kr;
      assign m_bd = xi * ki;
      assign m_ad = xr * ki;
      assign m_bc = xi * kr;
      assign pr   = PW'(m_ac) - PW'(m_bd);
      assign pi   = PW'(m_ad) + PW'(m_bc);

      always_ff @(posedge clk) begin
        if (in_fire) begin
          if (in_cin == '0) begin
            acc_re[in_row] <= AW'(pr);
            acc_im[in_row] <= AW'(pi);
          end else begin
            acc_re[in_row] <= acc_re[in_row] + AW'(pr);
            acc_im[in_row] <= acc_im[in_row] + AW'(pi);
          end
        end
      end

      assign rd_re[co][p] = acc_re[out_row];
      assign rd_im[co][p] = acc_im[out_row];
    end
  end

  for (genvar p = 0; p < FFTCHNL; p++) begin : g_out
    logic [DATALEN:0] rr, ri;
    assign rr = round_sat(rd_re[out_cout][p]);
    assign ri = round_sat(rd_im[out_cout][p]);
    assign out_word[p*W2 +: DATALEN]         = rr[DATALEN-1:0];
    assign out_word[p*W2+DATALEN +: DATALEN] = ri[DATALEN-1:0];
    assign clip_re[p] = rr[DATALEN];
    assign clip_im[p] = ri[DATALEN];
  end

endmodule

// File: tb/tb_spectral_mac_engine.sv
// Directed tiles for spectral_mac_engine, scored against a plain-arithmetic complex MAC model
// plus hand-computed literals for the constant tiles.
module tb_spectral_mac_engine;

  localparam int DATALEN = 16;
  localparam int FFTCHNL = 8;
  localparam int CIN     = 2;
  localparam int COUT    = 2;
  localparam int FRAC    = 15;
  localparam int W2      = 2 * DATALEN;
  localparam int ROWW    = FFTCHNL * W2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spectral_mac_engine_if #(.DATALEN(DATALEN), .FFTCHNL(FFTCHNL)) bus ();

  spectral_mac_engine #(
    .DATALEN(DATALEN), .FFTCHNL(FFTCHNL), .CIN(CIN), .COUT(COUT), .FRAC(FRAC)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int kre [COUT][CIN][FFTCHNL][FFTCHNL];
  int kim [COUT][CIN][FFTCHNL][FFTCHNL];
  int xre [CIN][FFTCHNL][FFTCHNL];
  int xim [CIN][FFTCHNL][FFTCHNL];
  logic [ROWW:0]   exp_q [$];
  logic [ROWW:0]   exp_e;
  logic [ROWW-1:0] last_data, prev_data;
  logic            prev_last;
  bit              prev_stall = 1'b0;
  bit              exp_sat;
  int              beats_seen = 0;

  task automatic check_output(input string name, input logic [ROWW-1:0] actual,
                              input logic [ROWW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: bound expired or beat not expected", name);
  endtask

  // Expected result: clip(floor((acc + 2^(FRAC-1)) / 2^FRAC)) to the signed DATALEN range.
  function automatic logic [DATALEN:0] to_fixed(input longint acc);
    longint v, q;
    v = acc + (longint'(1) << (FRAC - 1));
    if (v >= 0) q = v / (longint'(1) << FRAC);
    else        q = -((-v + (longint'(1) << FRAC) - 1) / (longint'(1) << FRAC));
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(q)};
  endfunction

  task automatic build_expected();
    logic [ROWW-1:0]  row;
    logic [DATALEN:0] fr, fi;
    longint sr, si;
    exp_sat = 1'b0;
    for (int co = 0; co < COUT; co++) begin
      for (int r = 0; r < FFTCHNL; r++) begin
        row = '0;
        for (int c = 0; c < FFTCHNL; c++) begin
          sr = 0;
          si = 0;
          for (int ci = 0; ci < CIN; ci++) begin
            sr += longint'(xre[ci][r][c]) * kre[co][ci][r][c] - longint'(xim[ci][r][c]) * kim[co][ci][r][c];
            si += longint'(xre[ci][r][c]) * kim[co][ci][r][c] + longint'(xim[ci][r][c]) * kre[co][ci][r][c];
          end
          fr = to_fixed(sr);
          fi = to_fixed(si);
          if (fr[DATALEN] || fi[DATALEN]) exp_sat = 1'b1;
          row[c*W2 +: 16]    = fr[15:0];
          row[c*W2+16 +: 16] = fi[15:0];
        end
        exp_q.push_back({(co == COUT - 1 && r == FFTCHNL - 1), row});
      end
    end
  endtask

  task automatic set_const(input int kr, input int ki, input int xr, input int xi);
    for (int co = 0; co < COUT; co++)
      for (int ci = 0; ci < CIN; ci++)
        for (int r = 0; r < FFTCHNL; r++)
          for (int c = 0; c < FFTCHNL; c++) begin
            kre[co][ci][r][c] = kr;
            kim[co][ci][r][c] = ki;
            xre[ci][r][c] = xr;
            xim[ci][r][c] = xi;
          end
  endtask

  task automatic set_pattern();
    for (int co = 0; co < COUT; co++)
      for (int ci = 0; ci < CIN; ci++)
        for (int r = 0; r < FFTCHNL; r++)
          for (int c = 0; c < FFTCHNL; c++) begin
            kre[co][ci][r][c] = ((co*131 + ci*71 + r*29 + c*13) * 2713) % 65536 - 32768;
            kim[co][ci][r][c] = ((co*17 + ci*53 + r*7 + c*101) * 1999) % 65536 - 32768;
            xre[ci][r][c] = ((ci*61 + r*37 + c*11) * 3301) % 65536 - 32768;
            xim[ci][r][c] = ((ci*19 + r*83 + c*3) * 4099) % 65536 - 32768;
          end
  endtask

  function automatic logic [ROWW-1:0] pack_row(input int ci, input int r);
    logic [ROWW-1:0] v;
    v = '0;
    for (int c = 0; c < FFTCHNL; c++) begin
      v[c*W2 +: 16]    = 16'(xre[ci][r][c]);
      v[c*W2+16 +: 16] = 16'(xim[ci][r][c]);
    end
    return v;
  endfunction

  task automatic apply_stimulus_kword(input logic [W2-1:0] w);
    @(negedge clk);
    bus.k_valid = 1'b1;
    bus.k_data  = w;
    for (int i = 0; i < 100 && !bus.k_ready; i++) @(negedge clk);
    if (!bus.k_ready) fail_now("k_ready_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_row(input int ci, input int r);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = pack_row(ci, r);
    for (int i = 0; i < 100 && !bus.in_ready; i++) @(negedge clk);
    if (!bus.in_ready) fail_now("in_ready_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic load_kernel();
    for (int co = 0; co < COUT; co++)
      for (int ci = 0; ci < CIN; ci++)
        for (int r = 0; r < FFTCHNL; r++)
          for (int c = 0; c < FFTCHNL; c++) begin
            apply_stimulus_kword({16'(kim[co][ci][r][c]), 16'(kre[co][ci][r][c])});
            if (co == 0 && ci == 0 && r == 0 && c == 0)
              check_output("k_loaded_clear_on_idx0", bus.k_loaded, 1'b0);
          end
    bus.k_valid = 1'b0;
    check_output("k_loaded_set_on_last", bus.k_loaded, 1'b1);
  endtask

  task automatic run_tile(input bit gaps, input bit stall, input bit use_lit,
                          input logic [15:0] lit_re, input logic [15:0] lit_im);
    build_expected();
    if (use_lit) begin
      check_output("model_pin_re", exp_q[0][15:0], lit_re);
      check_output("model_pin_im", exp_q[0][31:16], lit_im);
    end
    beats_seen = 0;
    for (int ci = 0; ci < CIN; ci++)
      for (int r = 0; r < FFTCHNL; r++) begin
        apply_stimulus_row(ci, r);
        if (gaps && (r % 3 == 1)) begin
          bus.in_valid = 1'b0;
          repeat (2) @(negedge clk);
        end
      end
    bus.in_valid = 1'b0;
    if (stall) begin
      for (int i = 0; i < 100 && beats_seen < 8; i++) @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
    end
    for (int i = 0; i < 300 && (exp_q.size() != 0 || bus.out_valid); i++) @(negedge clk);
    if (exp_q.size() != 0 || bus.out_valid) fail_now("drain_timeout");
    check_output("beat_count", beats_seen, 16);
    check_output("idle_out_valid", bus.out_valid, 1'b0);
    check_output("idle_busy", bus.busy, 1'b0);
    check_output("tile_sat_flag", bus.sat_flag, exp_sat);
    if (use_lit) begin
      check_output("lit_last_re", last_data[15:0], lit_re);
      check_output("lit_last_im", last_data[31:16], lit_im);
    end
  endtask

  // Scoreboard: every transferred beat against the model, every stalled beat against the previous cycle.
  always @(negedge clk) begin
    if (rstn && bus.out_valid) begin
      if (prev_stall) begin
        check_output("stall_data", bus.out_data, prev_data);
        check_output("stall_last", bus.out_last, prev_last);
      end
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          exp_e = exp_q.pop_front();
          check_output("beat_data", bus.out_data, exp_e[ROWW-1:0]);
          check_output("beat_last", bus.out_last, exp_e[ROWW]);
        end
        beats_seen++;
        last_data = bus.out_data;
      end
      prev_stall = !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end else begin
      if (prev_stall && rstn) check_output("stall_valid_held", bus.out_valid, 1'b1);
      prev_stall = 1'b0;
    end
  end

  task automatic check_output_idle_after_reset();
    check_output("rst_k_ready", bus.k_ready, 1'b1);
    check_output("rst_in_ready", bus.in_ready, 1'b0);
    check_output("rst_k_loaded", bus.k_loaded, 1'b0);
    check_output("rst_out_valid", bus.out_valid, 1'b0);
    check_output("rst_out_last", bus.out_last, 1'b0);
    check_output("rst_busy", bus.busy, 1'b0);
    check_output("rst_sat_flag", bus.sat_flag, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.k_valid   = 1'b0;
    bus.k_data    = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rstn          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_output_idle_after_reset();

    $display("[TB] tile A: real 0.5 x 0.5 over two channels");
    set_const(16'h4000, 0, 16'h4000, 0);
    load_kernel();
    @(negedge clk);
    check_output("in_ready_idle", bus.in_ready, 1'b1);
    bus.k_valid = 1'b1;
    #1;
    check_output("kernel_priority", bus.in_ready, 1'b0);
    bus.k_valid = 1'b0;
    #1;
    run_tile(1'b0, 1'b0, 1'b1, 16'h4000, 16'h0000);

    $display("[TB] tile B: j0.5 x j0.5");
    set_const(0, 16'h4000, 0, 16'h4000);
    load_kernel();
    run_tile(1'b0, 1'b0, 1'b1, 16'hC000, 16'h0000);

    $display("[TB] tile C: saturating real product");
    set_const(16'h7FFF, 0, 16'h7FFF, 0);
    load_kernel();
    run_tile(1'b0, 1'b0, 1'b1, 16'h7FFF, 16'h0000);
    check_output("c_sat_literal", bus.sat_flag, 1'b1);

    $display("[TB] tile D: patterned data, input gaps, output stall at beat 9");
    set_pattern();
    load_kernel();
    run_tile(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);

    $display("[TB] tile E: reset after six rows, reload, full tile");
    set_const(16'h4000, 0, 16'h4000, 0);
    load_kernel();
    set_pattern();
    for (int r = 0; r < 6; r++) apply_stimulus_row(0, r);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_output("accum_busy", bus.busy, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_output_idle_after_reset();
    set_const(16'h4000, 0, 16'h4000, 0);
    load_kernel();
    run_tile(1'b0, 1'b0, 1'b1, 16'h4000, 16'h0000);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
